// File: rtl/branch_resolve_unit_pkg.sv
// Shared types and constants for the branch resolve unit.
// GHR_LENGTH_DEF sizes the update record and is the default history width of the top.
package branch_resolve_unit_pkg;

  localparam int unsigned GHR_LENGTH_DEF = 8;

  // Fall-through PC skips the branch and its delay slot.
  localparam logic [31:0] DELAY_SLOT_OFS = 32'd8;

  typedef enum logic {
    IDLE,
    RECOVER
  } bruState_t;

  // One PHT update: branch PC, history used to index, resolved direction.
  typedef struct packed {
    logic [31:0]               pc;
    logic [GHR_LENGTH_DEF-1:0] ghr;
    logic                      take;
  } updRec_t;

endpackage

// File: rtl/bru_upd_fifo.sv
// Synchronous FIFO of PHT update records with full/empty flags.
// Depth must be a power of two (>= 2) so the pointers wrap naturally.
module bru_upd_fifo
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    pushValid,
  input  updRec_t pushData,
  input  logic    popReady,
  output logic    popValid,
  output updRec_t popData,
  output logic    full,
  output logic    empty
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

  updRec_t         mem [Depth];
  logic [PtrW-1:0] wrPtrQ, rdPtrQ;
  logic [CntW-1:0] countQ, countD;
  logic            doPush, doPop;

  assign full     = (countQ == DepthCnt);
  assign empty    = (countQ == '0);
  assign popValid = ~empty;
  assign popData  = mem[rdPtrQ];

  // Guard both sides so an illegal request can never corrupt occupancy.
  assign doPush = pushValid & ~full;
  assign doPop  = popReady & ~empty;

  // Occupancy follows push/pop; simultaneous push and pop cancel out.
  always_comb begin
    countD = countQ;
    unique case ({doPush, doPop})
      2'b10:   countD = countQ + CntW'(1);
      2'b01:   countD = countQ - CntW'(1);
      default: countD = countQ;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtrQ <= '0;
      rdPtrQ <= '0;
      countQ <= '0;
    end else begin
      if (doPush) wrPtrQ <= wrPtrQ + PtrW'(1);
      if (doPop)  rdPtrQ <= rdPtrQ + PtrW'(1);
      countQ <= countD;
    end
  end

  // Storage needs no reset; entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtrQ] <= pushData;
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: detects EX-stage mispredicts, issues a one-cycle redirect with the
// corrected PC and history, and queues every resolved branch as a PHT update.
// Optional macro BRU_PERF_CNT_EN adds saturating branch/mispredict counters.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned GHR_LENGTH = GHR_LENGTH_DEF,
  parameter int unsigned UPD_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  branchE,
  input  logic                  stallE,
  input  logic                  pred_takeE,
  input  logic                  actual_takeE,
  input  logic [31:0]           pcE,
  input  logic [31:0]           targetE,
  input  logic [GHR_LENGTH-1:0] ghrE,
  output logic                  redirect_valid,
  output logic [31:0]           redirect_pc,
  output logic [GHR_LENGTH-1:0] ghr_fix,
  output logic                  flush_req,
  output logic                  stall_req,
  output logic                  upd_valid,
  input  logic                  upd_ready,
  output logic [31:0]           upd_pc,
  output logic [GHR_LENGTH-1:0] upd_ghr,
  output logic                  upd_take
`ifdef BRU_PERF_CNT_EN
  ,
  output logic [31:0]           br_cnt,
  output logic [31:0]           mis_cnt
`endif
);

  bruState_t             stateQ, stateD;
  logic                  accept, mispred, fifoFull, fifoEmpty;
  logic [31:0]           redirectPcQ;
  logic [GHR_LENGTH-1:0] ghrFixQ;
  updRec_t               pushRec, headRec;

  // stall_req comes from occupancy before this cycle's pop, so full blocks a push even
  // when the head is leaving in the same cycle.
  assign stall_req = fifoFull;
  assign accept    = branchE & ~stallE & ~fifoFull & (stateQ == IDLE);
  assign mispred   = pred_takeE ^ actual_takeE;

  // Next-state: a mispredict opens a single recovery cycle.
  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      IDLE:    if (accept && mispred) stateD = RECOVER;
      RECOVER: stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stateQ <= IDLE;
    else      stateQ <= stateD;
  end

  // The recovery cycle is exactly the redirect pulse.
  assign redirect_valid = (stateQ == RECOVER);
  assign flush_req      = redirect_valid;
  assign redirect_pc    = redirectPcQ;
  assign ghr_fix        = ghrFixQ;

  // Capture corrected fetch PC and history on an accepted mispredict; hold otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      redirectPcQ <= '0;
      ghrFixQ     <= '0;
    end else if (accept && mispred) begin
      redirectPcQ <= actual_takeE ? targetE : (pcE + DELAY_SLOT_OFS);
      ghrFixQ     <= {ghrE[GHR_LENGTH-2:0], actual_takeE};
    end
  end

  // Update record built from the branch as seen at accept.
  always_comb begin
    pushRec      = '0;
    pushRec.pc   = pcE;
    pushRec.ghr  = ghrE;
    pushRec.take = actual_takeE;
  end

  bru_upd_fifo #(
    .Depth (UPD_DEPTH)
  ) u_upd_fifo (
    .clk       (clk),
    .rst       (rst),
    .pushValid (accept),
    .pushData  (pushRec),
    .popReady  (upd_ready),
    .popValid  (upd_valid),
    .popData   (headRec),
    .full      (fifoFull),
    .empty     (fifoEmpty)
  );

  assign upd_pc   = headRec.pc;
  assign upd_ghr  = headRec.ghr;
  assign upd_take = headRec.take;

`ifdef BRU_PERF_CNT_EN
  logic [31:0] brCntQ, misCntQ;

  // Saturating event counters for accepted branches and mispredicts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      brCntQ  <= '0;
      misCntQ <= '0;
    end else if (accept) begin
      if (brCntQ != 32'hFFFF_FFFF)              brCntQ  <= brCntQ + 32'd1;
      if (mispred && misCntQ != 32'hFFFF_FFFF) misCntQ <= misCntQ + 32'd1;
    end
  end

  assign br_cnt  = brCntQ;
  assign mis_cnt = misCntQ;
`else
  // Counters absent; fifoEmpty is otherwise only consumed inside the FIFO flags.
`endif

  logic unusedEmpty;
  assign unusedEmpty = fifoEmpty;

endmodule
